// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with write-back bypass, load-use bubble, flush and hold
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add the bubble_count port and its counter.
module id_ex_pipe #(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // decode stage
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_readdata1,
  input  logic [31:0]       id_readdata2,
  input  logic [31:0]       id_imm,
  input  logic              id_memread,
  input  logic              id_regwrite,
  input  logic [CTRL_W-1:0] id_ctrl,
  // write-back stage
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_writereg,
  input  logic [31:0]       wb_writedata,
  // pipeline control
  input  logic              hold,
  input  logic              flush,
  output logic              stall_id,
  // execute stage
  output logic              ex_valid,
  output logic              ex_memread,
  output logic              ex_regwrite,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_count
`endif
);

  logic [31:0] byp_a;
  logic [31:0] byp_b;
  logic        wb_hit_rs;
  logic        wb_hit_rt;
  logic        load_use_rs;
  logic        load_use_rt;
  logic        hazard;

  // Write-back bypass: the register file returns stale data when it is
  // written and read in the same cycle, so take the value being written.
  // Register 0 is hard-wired to zero and never bypassed.
  always_comb begin
    wb_hit_rs = wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == id_rs);
    wb_hit_rt = wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == id_rt);
    byp_a     = wb_hit_rs ? wb_writedata : id_readdata1;
    byp_b     = wb_hit_rt ? wb_writedata : id_readdata2;
  end

  // Load-use detection: a load in EX whose destination is a source of the
  // decoding instruction cannot be forwarded in time, so one bubble is needed.
  // Only registered EX state and ID inputs feed this, never hold or flush.
  always_comb begin
    load_use_rs = (ex_rt == id_rs);
    load_use_rt = (ex_rt == id_rt);
    hazard      = id_valid && ex_valid && ex_memread && (ex_rt != 5'd0)
                  && (load_use_rs || load_use_rt);
    stall_id    = hazard || hold;
  end

  // Pipeline register: flush beats hold, hold beats the bubble, else load.
  // Kills clear only the valid/control fields so data paths do not toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_memread  <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_ctrl     <= '0;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      ex_a        <= 32'd0;
      ex_b        <= 32'd0;
      ex_imm      <= 32'd0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_memread  <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_ctrl     <= '0;
    end else if (hold) begin
      ex_valid    <= ex_valid;
    end else if (hazard) begin
      ex_valid    <= 1'b0;
      ex_memread  <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_ctrl     <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_memread  <= id_valid && id_memread;
      ex_regwrite <= id_valid && id_regwrite;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_a        <= byp_a;
      ex_b        <= byp_b;
      ex_imm      <= id_imm;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // Count only bubbles that are actually inserted by the load-use hazard;
  // a flush or hold in the same cycle means no hazard bubble was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= 32'd0;
    end else if (hazard && !hold && !flush) begin
      bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule
